key_pulse_gen: RTL and testbench

//  Consumes a synchronized push-button level from the input flip-flop chain.

---
 rtl/frogger_input_pkg.sv | 30 +++
 rtl/key_event_counter.sv | 50 +++++
 rtl/key_pulse_gen.sv | 158 +++++++++++++++
 tb/tb_key_pulse_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/frogger_input_pkg.sv
// Shared definitions for the frogger push-button input path.
//
// Contents:
//   key_state_e        - per-key debounce/repeat FSM states
//   KEY_DEBOUNCE_*     - debounce lengths for the board clock and for simulation
//   KEY_REPEAT_*       - auto-repeat periods for the board clock and for simulation
//   cnt_width()        - counter width able to hold 0..limit, never narrower than 1 bit
package frogger_input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        HELD,
        RELEASING
    } key_state_e;

    // Board defaults assume a 50 MHz clock: 5 ms debounce, 200 ms repeat.
    localparam int unsigned KEY_DEBOUNCE_BOARD = 250000;
    localparam int unsigned KEY_DEBOUNCE_SIM   = 4;
    localparam int unsigned KEY_REPEAT_BOARD   = 10000000;
    localparam int unsigned KEY_REPEAT_SIM     = 8;

    // $clog2(limit+1) is 0 for limit==0, so clamp to a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_event_counter.sv
// Small up-counter with clear, load-one and enable controls plus a terminal-count flag.
// Used for both the debounce run length and the auto-repeat period.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset, clears the count
//   clear     in   count <= 0 (highest priority)
//   start     in   count <= 1 (the sample that triggered it already counts)
//   enable    in   count <= count + 1
//   terminal  out  count == LIMIT-1; held low when LIMIT == 0
module key_event_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic start,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (start) begin
            count_d = WIDTH'(1);
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The FSM never enables past LAST, so the counter cannot wrap.
    assign terminal = (LIMIT > 0) && (count_q == LAST);

endmodule

// File: rtl/key_pulse_gen.sv
// Debounces one synchronized push-button level and turns each accepted press into a
// single-cycle move strobe, optionally repeating the strobe while the key stays held.
// One instance per direction key, between the input synchronizers and the frog logic.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive equal samples to accept a press or release (>= 2)
//   REPEAT_CYCLES    cycles between auto-repeat strobes while held; 0 disables repeat
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   key_sync  in   synchronized key level, 1 = pressed
//   pulse     out  registered one-cycle move strobe
//   held      out  registered debounced key level
module key_pulse_gen
    import frogger_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_SIM,
    parameter int unsigned REPEAT_CYCLES   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic key_sync,
    output logic pulse,
    output logic held
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_W = cnt_width(REPEAT_CYCLES);

    key_state_e state_q;
    key_state_e state_d;
    logic       pulse_d;
    logic       held_d;

    logic cnt_clear;
    logic cnt_start;
    logic cnt_en;
    logic cnt_term;
    logic rpt_clear;
    logic rpt_en;
    logic rpt_term;

    key_event_counter #(
        .WIDTH (CNT_W),
        .LIMIT (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .start    (cnt_start),
        .enable   (cnt_en),
        .terminal (cnt_term)
    );

    key_event_counter #(
        .WIDTH (RPT_W),
        .LIMIT (REPEAT_CYCLES)
    ) u_repeat (
        .clk      (clk),
        .reset    (reset),
        .clear    (rpt_clear),
        .start    (1'b0),
        .enable   (rpt_en),
        .terminal (rpt_term)
    );

    // Next-state decode; also steers both counters so they move on the same edge.
    always_comb begin
        state_d   = state_q;
        pulse_d   = 1'b0;
        held_d    = held;
        cnt_clear = 1'b0;
        cnt_start = 1'b0;
        cnt_en    = 1'b0;
        rpt_clear = 1'b0;
        rpt_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_sync) begin
                    state_d   = ARMING;
                    cnt_start = 1'b1;
                end
            end

            ARMING: begin
                if (!key_sync) begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end else if (cnt_term) begin
                    state_d   = HELD;
                    pulse_d   = 1'b1;
                    held_d    = 1'b1;
                    rpt_clear = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            HELD: begin
                if (!key_sync) begin
                    state_d   = RELEASING;
                    cnt_start = 1'b1;
                end else if (REPEAT_CYCLES > 0) begin
                    if (rpt_term) begin
                        pulse_d   = 1'b1;
                        rpt_clear = 1'b1;
                    end else begin
                        rpt_en = 1'b1;
                    end
                end
            end

            RELEASING: begin
                // A bounce back high resumes HELD with the repeat phase untouched.
                if (key_sync) begin
                    state_d = HELD;
                end else if (cnt_term) begin
                    state_d = IDLE;
                    held_d  = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                held_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pulse   <= 1'b0;
            held    <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse   <= pulse_d;
            held    <= held_d;
        end
    end

    // held mirrors the debounced level carried by the state encoding.
    held_tracks_state: assert property (
        @(posedge clk) disable iff (!reset)
        held == (state_q inside {HELD, RELEASING})
    );

    // Back-to-back strobes are only possible with a one-cycle repeat period.
    no_double_pulse: assert property (
        @(posedge clk) disable iff (!reset)
        (REPEAT_CYCLES != 1 && pulse) |=> !pulse
    );

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: two instances (repeat every 8 cycles, repeat disabled) share one
// key and reset; expected outputs of both are queued when a key sample is driven and
// compared just after the clock edge that samples it.
module tb_key_pulse_gen;

    logic clk = 1'b0;
    logic reset;
    logic key_sync;
    logic pulse8;
    logic held8;
    logic pulse0;
    logic held0;

    always #5 clk = ~clk;

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_sync (key_sync),
        .pulse    (pulse8),
        .held     (held8)
    );

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (0)
    ) dut_norpt (
        .clk      (clk),
        .reset    (reset),
        .key_sync (key_sync),
        .pulse    (pulse0),
        .held     (held0)
    );

    typedef struct {
        logic  p8;
        logic  h8;
        logic  p0;
        logic  h0;
        string name;
    } exp_t;

    typedef struct packed {
        logic k;
        logic p8;
        logic h8;
        logic p0;
        logic h0;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: pulse8/held8/pulse0/held0 got %b want %b at %0t",
                     name, got, want, $time);
        end
    endtask

    // Scoreboard consumer: one expectation per sampling edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, {pulse8, held8, pulse0, held0}, {e.p8, e.h8, e.p0, e.h0});
        end
    end

    // Drive one key sample and queue what both instances must show after the edge.
    task automatic step(input logic k, input logic p8, input logic h8, input logic p0,
                        input logic h0, input string name);
        exp_t e;
        @(negedge clk);
        key_sync = k;
        e.p8   = p8;
        e.h8   = h8;
        e.p0   = p0;
        e.h0   = h0;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Key high for n edges from IDLE: press accepted on the 4th sample (index 3), then
    // repeat strobes every 8 edges on the repeating instance only.
    task automatic hold_run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            logic p8;
            p8 = (i == 3) || (i >= 11 && ((i - 3) % 8) == 0);
            step(1'b1, p8, i >= 3, i == 3, i >= 3, $sformatf("%s[%0d]", tag, i));
        end
    endtask

    // Assert reset between clock edges and confirm outputs drop before any edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check(name, {pulse8, held8, pulse0, held0}, 4'b0000);
    endtask

    initial begin
        reset    = 1'b0;
        key_sync = 1'b1;

        // Key held through reset: nothing may come out while reset is low.
        step(1'b1, 0, 0, 0, 0, "in_reset[0]");
        step(1'b1, 0, 0, 0, 0, "in_reset[1]");
        #3 reset = 1'b1;

        // Held through reset counts as a fresh press; 30 edges with repeats.
        hold_run(30, "hold30");

        // Starts in HELD with the repeat counter two cycles into its period.
        //                     k  p8 h8 p0 h0
        tbl.push_back(vec_t'(5'b0_0_1_0_1));  // bounce low: RELEASING
        tbl.push_back(vec_t'(5'b0_0_1_0_1));
        tbl.push_back(vec_t'(5'b1_0_1_0_1));  // back to HELD, repeat phase frozen
        tbl.push_back(vec_t'(5'b1_0_1_0_1));
        tbl.push_back(vec_t'(5'b1_0_1_0_1));
        tbl.push_back(vec_t'(5'b1_0_1_0_1));
        tbl.push_back(vec_t'(5'b1_0_1_0_1));
        tbl.push_back(vec_t'(5'b1_0_1_0_1));
        tbl.push_back(vec_t'(5'b1_1_1_0_1));  // repeat resumes where it left off
        tbl.push_back(vec_t'(5'b0_0_1_0_1));  // real release: 4 low samples
        tbl.push_back(vec_t'(5'b0_0_1_0_1));
        tbl.push_back(vec_t'(5'b0_0_1_0_1));
        tbl.push_back(vec_t'(5'b0_0_0_0_0));  // released after the 4th low sample
        tbl.push_back(vec_t'(5'b0_0_0_0_0));
        tbl.push_back(vec_t'(5'b1_0_0_0_0));  // 3-sample glitch: never accepted
        tbl.push_back(vec_t'(5'b1_0_0_0_0));
        tbl.push_back(vec_t'(5'b1_0_0_0_0));
        tbl.push_back(vec_t'(5'b0_0_0_0_0));
        tbl.push_back(vec_t'(5'b0_0_0_0_0));
        tbl.push_back(vec_t'(5'b1_0_0_0_0));  // single-sample glitch
        tbl.push_back(vec_t'(5'b0_0_0_0_0));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].k, tbl[i].p8, tbl[i].h8, tbl[i].p0, tbl[i].h0,
                 $sformatf("table[%0d]", i));
        end

        // Reset while held: held must drop without a clock edge.
        hold_run(6, "prehold");
        async_reset("async_reset_held");
        step(1'b1, 0, 0, 0, 0, "held_reset[0]");
        step(1'b1, 0, 0, 0, 0, "held_reset[1]");
        #3 reset = 1'b1;

        // Reset mid-ARMING discards the partial count.
        step(1'b1, 0, 0, 0, 0, "arming[0]");
        step(1'b1, 0, 0, 0, 0, "arming[1]");
        step(1'b1, 0, 0, 0, 0, "arming[2]");
        async_reset("async_reset_arming");
        step(1'b1, 0, 0, 0, 0, "arming_reset");
        #3 reset = 1'b1;

        // Long hold: one strobe only without repeat, six with repeat.
        hold_run(50, "hold50");
        step(1'b0, 0, 1, 0, 1, "release50[0]");
        step(1'b0, 0, 1, 0, 1, "release50[1]");
        step(1'b0, 0, 1, 0, 1, "release50[2]");
        step(1'b0, 0, 0, 0, 0, "release50[3]");

        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
